// File: rtl/audio_pkg.sv
// Shared constants and types for the audio unit playback path.
package audio_pkg;

    // Default bits per audio channel.
    localparam int SAMPLE_W = 24;

    // Playback serializer framing states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LEFT = 2'd1,
        LEFT      = 2'd2,
        RIGHT     = 2'd3
    } i2s_tx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/i2s_playback_serializer.sv
// Playback-side I2S / left-justified transmitter. Oversamples the CODEC's
// BCLK and LRC, pops one stereo word per frame from an FWFT FIFO at the left
// channel start, and shifts each channel out MSB-first on falling BCLK.
module i2s_playback_serializer #(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int CNT_W    = 16
) (
    input  logic                    board_clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    justification,
    input  logic                    ac_bclk,
    input  logic                    ac_pblrc,
    output logic                    ac_pbdat,
    input  logic [2*SAMPLE_W-1:0]   fifo_data,
    input  logic                    fifo_empty,
    output logic                    fifo_rd,
    output logic [CNT_W-1:0]        underrun_count,
    output logic                    busy
);

    import audio_pkg::*;

    localparam int                BCW      = $clog2(SAMPLE_W + 1);
    localparam logic [BCW-1:0]    BIT_LAST = BCW'(SAMPLE_W);

    logic bclk_s;
    logic lrc_s;
    logic bclk_prev_q;
    logic bclk_fall_s;
    logic left_start_s;
    logic right_start_s;
    logic frame_start_s;
    logic chan_right_s;

    i2s_tx_state_t state_q, state_d;

    logic                  lrc_prev_q,  lrc_prev_d;
    logic                  en_q,        en_d;
    logic                  just_q,      just_d;
    logic [2*SAMPLE_W-1:0] frame_q,     frame_d;
    logic [SAMPLE_W-1:0]   shift_q,     shift_d;
    logic [BCW-1:0]        bit_cnt_q,   bit_cnt_d;
    logic                  pbdat_q,     pbdat_d;
    logic [CNT_W-1:0]      uc_q,        uc_d;

    logic [SAMPLE_W-1:0]   chan_word_s;
    logic                  chan_just_s;

    sync_2ff u_sync_bclk (
        .clk_i (board_clk),
        .rst_i (reset),
        .d_i   (ac_bclk),
        .q_o   (bclk_s)
    );

    sync_2ff u_sync_lrc (
        .clk_i (board_clk),
        .rst_i (reset),
        .d_i   (ac_pblrc),
        .q_o   (lrc_s)
    );

    // Previous synced BCLK for falling-edge detection.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            bclk_prev_q <= 1'b0;
        end else begin
            bclk_prev_q <= bclk_s;
        end
    end

    assign bclk_fall_s   = bclk_prev_q & ~bclk_s;
    assign left_start_s  = bclk_fall_s & ~lrc_s &  lrc_prev_q;
    assign right_start_s = bclk_fall_s &  lrc_s & ~lrc_prev_q;
    assign frame_start_s = left_start_s & ((state_q == WAIT_LEFT) || (state_q == RIGHT));
    assign chan_right_s  = right_start_s & (state_q == LEFT);

    // FSM state register.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: align to a genuine LRC high-to-low before playing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bclk_fall_s)   state_d = WAIT_LEFT; else state_d = IDLE;
            WAIT_LEFT: if (left_start_s)  state_d = LEFT;      else state_d = WAIT_LEFT;
            LEFT:      if (right_start_s) state_d = RIGHT;     else state_d = LEFT;
            RIGHT:     if (left_start_s)  state_d = LEFT;      else state_d = RIGHT;
            default:                      state_d = IDLE;
        endcase
    end

    // FSM outputs: busy while playing, pop strobe in the left-start cycle.
    always_comb begin
        busy    = (state_q == LEFT) || (state_q == RIGHT);
        fifo_rd = frame_start_s & enable & ~fifo_empty;
    end

    // Datapath next-state: frame latch, channel load, bit shifting, underruns.
    always_comb begin
        lrc_prev_d = lrc_prev_q;
        en_d       = en_q;
        just_d     = just_q;
        frame_d    = frame_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        pbdat_d    = pbdat_q;
        uc_d       = uc_q;

        if (bclk_fall_s) begin
            lrc_prev_d = lrc_s;
        end else begin
            lrc_prev_d = lrc_prev_q;
        end

        if (frame_start_s) begin
            en_d   = enable;
            just_d = justification;
            if (enable && !fifo_empty) begin
                frame_d = fifo_data;
            end else begin
                frame_d = '0;
            end
            if (enable && fifo_empty && (uc_q != {CNT_W{1'b1}})) begin
                uc_d = uc_q + CNT_W'(1);
            end else begin
                uc_d = uc_q;
            end
        end else begin
            en_d = en_q;
        end

        // The left word comes straight from the new frame; the right from the latch.
        if (frame_start_s) begin
            chan_word_s = frame_d[2*SAMPLE_W-1:SAMPLE_W];
            chan_just_s = justification;
        end else begin
            chan_word_s = frame_q[SAMPLE_W-1:0];
            chan_just_s = just_q;
        end

        if (frame_start_s || chan_right_s) begin
            if (chan_just_s) begin
                // Left-justified: MSB goes out on the start edge itself.
                pbdat_d   = chan_word_s[SAMPLE_W-1];
                shift_d   = chan_word_s << 1;
                bit_cnt_d = BCW'(1);
            end else begin
                // I2S: one idle bit on the start edge, MSB on the next.
                pbdat_d   = 1'b0;
                shift_d   = chan_word_s;
                bit_cnt_d = '0;
            end
        end else if (bclk_fall_s && busy) begin
            if (bit_cnt_q < BIT_LAST) begin
                pbdat_d   = shift_q[SAMPLE_W-1] & en_q;
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q + BCW'(1);
            end else begin
                pbdat_d   = 1'b0;
            end
        end else begin
            pbdat_d = pbdat_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            lrc_prev_q <= 1'b0;
            en_q       <= 1'b0;
            just_q     <= 1'b0;
            frame_q    <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            pbdat_q    <= 1'b0;
            uc_q       <= '0;
        end else begin
            lrc_prev_q <= lrc_prev_d;
            en_q       <= en_d;
            just_q     <= just_d;
            frame_q    <= frame_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            pbdat_q    <= pbdat_d;
            uc_q       <= uc_d;
        end
    end

    assign ac_pbdat       = pbdat_q;
    assign underrun_count = uc_q;

endmodule

// File: tb/tb_i2s_playback_serializer.sv
// Directed bench for i2s_playback_serializer: drives a CODEC-style BCLK/LRC
// (10 board clocks per BCLK, 64 BCLK per frame) and captures each 32-bit slot.
module tb_i2s_playback_serializer;

    logic        board_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        justification;
    logic        ac_bclk;
    logic        ac_pblrc;
    logic        ac_pbdat;
    logic [47:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [15:0] underrun_count;
    logic        busy;

    logic        s_pbdat;
    logic        s_fifo_rd;
    logic [1:0]  s_underrun_count;
    logic        s_busy;

    int checks = 0;
    int errors = 0;
    int rd_total = 0;

    always #5 board_clk = ~board_clk;

    i2s_playback_serializer #(.SAMPLE_W(24), .CNT_W(16)) dut (
        .board_clk      (board_clk),
        .reset          (reset),
        .enable         (enable),
        .justification  (justification),
        .ac_bclk        (ac_bclk),
        .ac_pblrc       (ac_pblrc),
        .ac_pbdat       (ac_pbdat),
        .fifo_data      (fifo_data),
        .fifo_empty     (fifo_empty),
        .fifo_rd        (fifo_rd),
        .underrun_count (underrun_count),
        .busy           (busy)
    );

    // Narrow-counter instance used to observe saturation quickly.
    i2s_playback_serializer #(.SAMPLE_W(24), .CNT_W(2)) dut_sat (
        .board_clk      (board_clk),
        .reset          (reset),
        .enable         (enable),
        .justification  (justification),
        .ac_bclk        (ac_bclk),
        .ac_pblrc       (ac_pblrc),
        .ac_pbdat       (s_pbdat),
        .fifo_data      (fifo_data),
        .fifo_empty     (fifo_empty),
        .fifo_rd        (s_fifo_rd),
        .underrun_count (s_underrun_count),
        .busy           (s_busy)
    );

    // Count pop strobes of the main instance.
    always @(negedge board_clk) begin
        if (fifo_rd === 1'b1) rd_total = rd_total + 1;
    end

    typedef struct {
        logic        en;
        logic        just;
        logic        empty;
        logic [47:0] data;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
        int          exp_rd;
        logic [15:0] exp_uc;
        logic [1:0]  exp_suc;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] i2s_slot(input logic [23:0] w);
        return {1'b0, w, 7'b0000000};
    endfunction

    function automatic logic [31:0] lj_slot(input logic [23:0] w);
        return {w, 8'h00};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One slot of n BCLK periods at a fixed LRC level; bit i sampled 4 clocks after fall i.
    task automatic run_half(input logic lrc, input int n, input int drop_at, input int rst_at,
                            output logic [31:0] cap);
        logic rel;
        cap = 32'h0;
        rel = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge board_clk);
            ac_bclk  = 1'b0;
            ac_pblrc = lrc;
            repeat (4) @(negedge board_clk);
            cap = {cap[30:0], ac_pbdat};
            if (i == drop_at) enable = 1'b0;
            if (i == rst_at) begin
                check("pbdat_before_reset", 64'(ac_pbdat), 64'd1);
                check("uc_before_reset_nonzero", 64'(underrun_count != 16'd0), 64'd1);
                #2 reset = 1'b1;
                #1;
                check("rst_async_pbdat", 64'(ac_pbdat), 64'd0);
                check("rst_async_fifo_rd", 64'(fifo_rd), 64'd0);
                check("rst_async_busy", 64'(busy), 64'd0);
                check("rst_async_uc", 64'(underrun_count), 64'd0);
                rel = 1'b1;
            end
            @(negedge board_clk);
            ac_bclk = 1'b1;
            if (rel) begin
                reset = 1'b0;
                rel   = 1'b0;
            end
            repeat (4) @(negedge board_clk);
        end
    endtask

    task automatic run_frame(input int drop_at, input int rst_at,
                             output logic [31:0] cl, output logic [31:0] cr, output int rds);
        int rd0;
        rd0 = rd_total;
        run_half(1'b0, 32, drop_at, -1, cl);
        run_half(1'b1, 32, -1, rst_at, cr);
        rds = rd_total - rd0;
    endtask

    initial begin
        logic [31:0] cl;
        logic [31:0] cr;
        int          rds;
        int          rd0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 48'hABCDEF_123456, i2s_slot(24'hABCDEF), i2s_slot(24'h123456), 1, 16'd0, 2'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 48'hABCDEF_123456, lj_slot(24'hABCDEF),  lj_slot(24'h123456),  1, 16'd0, 2'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 48'hABCDEF_123456, 32'h0, 32'h0, 0, 16'd1, 2'd1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 48'hABCDEF_123456, 32'h0, 32'h0, 0, 16'd2, 2'd2};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 48'hABCDEF_123456, 32'h0, 32'h0, 0, 16'd3, 2'd3};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 48'hABCDEF_123456, 32'h0, 32'h0, 0, 16'd4, 2'd3};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 48'h5A5A5A_A5A5A5, 32'h0, 32'h0, 0, 16'd4, 2'd3};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 48'h800001_7FFFFE, i2s_slot(24'h800001), i2s_slot(24'h7FFFFE), 1, 16'd4, 2'd3};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 48'hFFFFFF_000001, lj_slot(24'hFFFFFF),  lj_slot(24'h000001),  1, 16'd4, 2'd3};

        reset         = 1'b1;
        enable        = 1'b0;
        justification = 1'b0;
        ac_bclk       = 1'b1;
        ac_pblrc      = 1'b1;
        fifo_data     = 48'h0;
        fifo_empty    = 1'b1;
        repeat (3) @(negedge board_clk);
        check("reset_pbdat", 64'(ac_pbdat), 64'd0);
        check("reset_fifo_rd", 64'(fifo_rd), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_uc", 64'(underrun_count), 64'd0);
        reset = 1'b0;

        // Right-channel lead-in so the first frame sees an LRC high-to-low.
        rd0 = rd_total;
        run_half(1'b1, 32, -1, -1, cr);
        check("leadin_silent", 64'(cr), 64'd0);
        check("leadin_no_pop", 64'(rd_total - rd0), 64'd0);

        for (int v = 0; v < 9; v++) begin
            enable        = vecs[v].en;
            justification = vecs[v].just;
            fifo_empty    = vecs[v].empty;
            fifo_data     = vecs[v].data;
            run_frame(-1, -1, cl, cr, rds);
            check($sformatf("vec%0d_left", v), 64'(cl), 64'(vecs[v].exp_l));
            check($sformatf("vec%0d_right", v), 64'(cr), 64'(vecs[v].exp_r));
            check($sformatf("vec%0d_pops", v), 64'(rds), 64'(vecs[v].exp_rd));
            check($sformatf("vec%0d_uc", v), 64'(underrun_count), 64'(vecs[v].exp_uc));
            check($sformatf("vec%0d_uc_sat", v), 64'(s_underrun_count), 64'(vecs[v].exp_suc));
            check($sformatf("vec%0d_busy", v), 64'(busy), 64'd1);
        end

        // Enable dropped mid-left: this frame intact, next frame silent, no pop/count.
        enable        = 1'b1;
        justification = 1'b0;
        fifo_empty    = 1'b0;
        fifo_data     = 48'hC3C3C3_3C3C3C;
        run_frame(10, -1, cl, cr, rds);
        check("drop_left", 64'(cl), 64'(i2s_slot(24'hC3C3C3)));
        check("drop_right", 64'(cr), 64'(i2s_slot(24'h3C3C3C)));
        check("drop_pops", 64'(rds), 64'd1);
        run_frame(-1, -1, cl, cr, rds);
        check("after_drop_left", 64'(cl), 64'd0);
        check("after_drop_right", 64'(cr), 64'd0);
        check("after_drop_pops", 64'(rds), 64'd0);
        check("after_drop_uc", 64'(underrun_count), 64'd4);

        // Async reset mid-right slot, then recovery with an underrun frame.
        enable     = 1'b1;
        fifo_data  = 48'h000000_FFFFFF;
        run_frame(-1, 5, cl, cr, rds);
        check("rstseq_left", 64'(cl), 64'(i2s_slot(24'h000000)));
        check("rstseq_pops", 64'(rds), 64'd1);
        fifo_empty = 1'b1;
        run_frame(-1, -1, cl, cr, rds);
        check("post_rst_silent", 64'(cl), 64'd0);
        check("post_rst_pops", 64'(rds), 64'd0);
        check("post_rst_uc", 64'(underrun_count), 64'd1);

        // Reset released with LRC low: nothing until the next LRC high-to-low.
        reset      = 1'b1;
        ac_pblrc   = 1'b0;
        ac_bclk    = 1'b1;
        fifo_empty = 1'b0;
        fifo_data  = 48'h13579B_2468AC;
        repeat (3) @(negedge board_clk);
        reset = 1'b0;
        rd0 = rd_total;
        run_half(1'b0, 16, -1, -1, cl);
        run_half(1'b1, 32, -1, -1, cr);
        check("midleft_rel_left", 64'(cl), 64'd0);
        check("midleft_rel_right", 64'(cr), 64'd0);
        check("midleft_rel_pops", 64'(rd_total - rd0), 64'd0);
        check("midleft_rel_busy", 64'(busy), 64'd0);
        run_frame(-1, -1, cl, cr, rds);
        check("first_full_left", 64'(cl), 64'(i2s_slot(24'h13579B)));
        check("first_full_right", 64'(cr), 64'(i2s_slot(24'h2468AC)));
        check("first_full_pops", 64'(rds), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
